// File: rtl/mux_tree_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_sequencer_if
// Description : Handshake bundle for the mux-tree sequencer. Carries the
//               input vector with its valid/ready pair and the clear strobe,
//               plus the result valid/ready pair, history and result counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_tree_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       x;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic             v;
    logic [3:0]       hist;
    logic [CNT_W-1:0] count;

    // Producer/consumer side: drives requests, observes results
    modport master (
        output in_valid, x, clear, out_ready,
        input  in_ready, out_valid, v, hist, count
    );

    // Sequencer side
    modport slave (
        input  in_valid, x, clear, out_ready,
        output in_ready, out_valid, v, hist, count
    );
endinterface
`default_nettype wire

// File: rtl/mux_tree_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_sequencer
// Description : Evaluates a 4-layer 2:1 mux tree (8->4->2->1), one layer per
//               clock. Layer 1 is selected by the previously accepted vector,
//               layers 2..4 by a history of committed results. The result is
//               held on a valid/ready handshake; a wrapping counter tracks
//               committed results.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_sequencer #(
    parameter logic [7:0] PREV_INIT = 8'h00,
    parameter logic [3:0] HIST_INIT = 4'b0000,
    parameter int         CNT_W     = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mux_tree_sequencer_if.slave     bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_L1   = 3'd1;
    localparam logic [2:0] c_L2   = 3'd2;
    localparam logic [2:0] c_L3   = 3'd3;
    localparam logic [2:0] c_L4   = 3'd4;
    localparam logic [2:0] c_OUT  = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;

    logic [7:0]       r_x;
    logic [7:0]       r_prev;
    logic [7:0]       r_o;
    logic [3:0]       r_t;
    logic [1:0]       r_u;
    logic             r_v;
    logic             r_out_valid;
    logic [3:0]       r_hist;       // {h4,h3,h2,h1}
    logic [CNT_W-1:0] r_count;

    // FSM decode outputs
    logic w_in_ready;
    logic w_accept;
    logic w_clear;
    logic w_do_l1;
    logic w_do_l2;
    logic w_do_l3;
    logic w_do_l4;
    logic w_commit;

    // Layer-1 mux outputs: bit i picks between x[i] and its upper neighbour
    logic [7:0] w_l1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_l1
            assign w_l1[gi] = r_prev[gi] ? r_x[(gi + 1) % 8] : r_x[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one layer per clock, IDLE waits for input, OUT waits for consumer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid)  w_state_nxt = c_L1;
            c_L1:                       w_state_nxt = c_L2;
            c_L2:                       w_state_nxt = c_L3;
            c_L3:                       w_state_nxt = c_L4;
            c_L4:                       w_state_nxt = c_OUT;
            c_OUT:   if (bus.out_ready) w_state_nxt = c_IDLE;
            default:                    w_state_nxt = c_IDLE;
        endcase
    end

    // Output decode: per-state enables for the datapath and the ready flag
    always_comb begin
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_clear    = 1'b0;
        w_do_l1    = 1'b0;
        w_do_l2    = 1'b0;
        w_do_l3    = 1'b0;
        w_do_l4    = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                // An accept in the same cycle takes priority over clear
                w_clear    = bus.clear & ~bus.in_valid;
            end
            c_L1:    w_do_l1  = 1'b1;
            c_L2:    w_do_l2  = 1'b1;
            c_L3:    w_do_l3  = 1'b1;
            c_L4:    w_do_l4  = 1'b1;
            c_OUT:   w_commit = r_out_valid & bus.out_ready;
            default: ;
        endcase
    end

    // Capture the accepted input vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= 8'h00;
        end else if (w_accept) begin
            r_x <= bus.x;
        end
    end

    // Tree layers 1..3; selects come from prev and the stable history bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o <= 8'h00;
            r_t <= 4'h0;
            r_u <= 2'b00;
        end else begin
            if (w_do_l1) begin
                r_o <= w_l1;
            end
            if (w_do_l2) begin
                for (int j = 0; j < 4; j++) begin
                    r_t[j] <= r_hist[3] ? r_o[2*j+1] : r_o[2*j];
                end
            end
            if (w_do_l3) begin
                for (int k = 0; k < 2; k++) begin
                    r_u[k] <= r_hist[2] ? r_t[2*k+1] : r_t[2*k];
                end
            end
        end
    end

    // Layer 4 produces the result; it holds until the next evaluation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v         <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_do_l4) begin
            r_v         <= r_hist[1] ? r_u[1] : r_u[0];
            r_out_valid <= 1'b1;
        end else if (w_commit) begin
            r_out_valid <= 1'b0;
        end
    end

    // Commit updates history, prev and counter; clear reloads the select sources
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= PREV_INIT;
            r_hist  <= HIST_INIT;
            r_count <= '0;
        end else if (w_commit) begin
            r_hist  <= {r_hist[2:0], r_v};
            r_prev  <= r_x;
            r_count <= r_count + CNT_W'(1);
        end else if (w_clear) begin
            r_prev  <= PREV_INIT;
            r_hist  <= HIST_INIT;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.v         = r_v;
    assign bus.hist      = r_hist;
    assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_tree_sequencer
// Description : Directed bench for mux_tree_sequencer. Two instances (16-bit
//               and 2-bit counters) share one stimulus stream; a reference
//               model predicts each result, queued at accept and compared at
//               commit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_tree_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       clear;
    logic       out_ready;
    logic [7:0] x;

    always #5 clk = ~clk;

    mux_tree_sequencer_if #(.CNT_W(16)) ifa ();
    mux_tree_sequencer_if #(.CNT_W(2))  ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.x         = x;
    assign ifa.clear     = clear;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.x         = x;
    assign ifb.clear     = clear;
    assign ifb.out_ready = out_ready;

    mux_tree_sequencer #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mux_tree_sequencer #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference state
    logic [7:0] prev_m;
    logic [3:0] hist_m;
    int         cnt_m;
    logic       sb_q[$];
    int         errors = 0;
    int         checks = 0;

    function automatic logic model_v(input logic [7:0] xi, input logic [7:0] pv,
                                     input logic [3:0] h);
        logic [7:0] o;
        logic [3:0] t;
        logic [1:0] u;
        for (int i = 0; i < 8; i++) o[i] = pv[i] ? xi[(i + 1) % 8] : xi[i];
        for (int j = 0; j < 4; j++) t[j] = h[3] ? o[2*j+1] : o[2*j];
        for (int k = 0; k < 2; k++) u[k] = h[2] ? t[2*k+1] : t[2*k];
        return h[1] ? u[1] : u[0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = cycles of out_ready=0 in OUT, clr = clear alongside accept
    task automatic send(input logic [7:0] xv, input int hold, input logic clr);
        int   n;
        logic exp_v;
        logic v_hold;
        n = 0;
        while (!ifa.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", 32'(ifa.in_ready), 32'd1);
        x = xv; in_valid = 1'b1; clear = clr; out_ready = (hold == 0);
        sb_q.push_back(model_v(xv, prev_m, hist_m));
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
        check("in_ready_busy", 32'(ifa.in_ready), 32'd0);
        n = 0;
        while (!ifa.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'd4);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            exp_v = 1'b0;
        end else begin
            exp_v = sb_q.pop_front();
        end
        check("v_a", 32'(ifa.v), 32'(exp_v));
        check("v_b", 32'(ifb.v), 32'(exp_v));
        v_hold = ifa.v;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x = ~xv ^ 8'(i);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(ifa.out_valid), 32'd1);
            check("bp_v", 32'(ifa.v), 32'(v_hold));
            check("bp_in_ready", 32'(ifa.in_ready), 32'd0);
            check("bp_count", 32'(ifa.count), 32'(cnt_m[15:0]));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        hist_m = {hist_m[2:0], exp_v};
        prev_m = xv;
        cnt_m++;
        check("commit_out_valid", 32'(ifa.out_valid), 32'd0);
        check("commit_in_ready", 32'(ifa.in_ready), 32'd1);
        check("commit_v_held", 32'(ifa.v), 32'(exp_v));
        check("hist_a", 32'(ifa.hist), 32'(hist_m));
        check("hist_b", 32'(ifb.hist), 32'(hist_m));
        check("count_a", 32'(ifa.count), 32'(cnt_m[15:0]));
        check("count_b", 32'(ifb.count), 32'(cnt_m[1:0]));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(ifa.out_valid), 32'd0);
        check({tag, "_v"},         32'(ifa.v),         32'd0);
        check({tag, "_count_a"},   32'(ifa.count),     32'd0);
        check({tag, "_count_b"},   32'(ifb.count),     32'd0);
        check({tag, "_hist"},      32'(ifa.hist),      32'd0);
        check({tag, "_in_ready"},  32'(ifa.in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1; x = 8'h00;
        prev_m = 8'h00; hist_m = 4'b0000; cnt_m = 0;
        #1;
        check_reset_state("rst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic sequence from the test plan
        send(8'h01, 0, 1'b0);   // v=1, hist=0001, count=1
        send(8'h01, 0, 1'b0);   // v=0 via prev[0], hist=0010, count=2
        send(8'h02, 3, 1'b0);   // v=0 via h2, with 3 cycles of backpressure

        // Reset while in L2: transaction abandoned
        x = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;     // accepted, now L1
        in_valid = 1'b0;
        @(posedge clk); #1;     // now L2
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        prev_m = 8'h00; hist_m = 4'b0000; cnt_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        send(8'h01, 0, 1'b0);                  // v=1 after reset, count 1
        send(8'h5C, 0, 1'b1);                  // clear together with accept is ignored
        send(8'($urandom_range(0, 255)), 2, 1'b0);
        send(8'($urandom_range(0, 255)), 0, 1'b0);  // 2-bit counter wraps to 0

        // Standalone clear in IDLE reloads prev and history, count untouched
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        prev_m = 8'h00; hist_m = 4'b0000;
        check("clear_hist_a", 32'(ifa.hist), 32'd0);
        check("clear_hist_b", 32'(ifb.hist), 32'd0);
        check("clear_count_a", 32'(ifa.count), 32'(cnt_m));
        check("clear_in_ready", 32'(ifa.in_ready), 32'd1);

        send(8'hB6, 0, 1'b0);                  // exercises prev after clear; count_b=1
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), i % 2, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
